// File: rtl/sensor_fusion_voter.sv
// sensor_fusion_voter
//   Conditions the raw IR, vibration and RFID detectors of every crossing into
//   one clean train-presence signal. Each raw input is synchronised, debounced
//   and majority-voted. Arrival/departure pulses and sticky per-sensor fault
//   flags are also produced.
//
// Ports
//   clk_50mhz     : system clock, rising edge
//   rst_n         : asynchronous active-low reset
//   ir_sensor     : raw IR detector, bit i = crossing i
//   vib_sensor    : raw vibration detector
//   rfid_valid    : raw RFID tag-valid
//   weather_mode  : 00 clear, 01 fog, 10/11 storm (synchronised internally)
//   train_present : crossing occupied (OCCUPIED or CLEARING)
//   train_arrive  : 1-cycle pulse on IDLE->OCCUPIED
//   train_depart  : 1-cycle pulse on CLEARING->IDLE
//   sensor_fault  : sticky fault flags, [3i+0]=IR, [3i+1]=VIB, [3i+2]=RFID
//
// Build option
//   FAULT_AUTOCLEAR_EN : when defined, a crossing whose three debounced sensors
//   agree for FAULT_TIMEOUT consecutive cycles has its fault flags cleared.
//   When undefined, faults stay set until reset.
module sensor_fusion_voter #(
  parameter int N_CROSS       = 4,
  parameter int DEBOUNCE_CYC  = 16,
  parameter int CLEAR_HOLD    = 64,
  parameter int FAULT_TIMEOUT = 1024
) (
  input  logic                 clk_50mhz,
  input  logic                 rst_n,
  input  logic [N_CROSS-1:0]   ir_sensor,
  input  logic [N_CROSS-1:0]   vib_sensor,
  input  logic [N_CROSS-1:0]   rfid_valid,
  input  logic [1:0]           weather_mode,
  output logic [N_CROSS-1:0]   train_present,
  output logic [N_CROSS-1:0]   train_arrive,
  output logic [N_CROSS-1:0]   train_depart,
  output logic [3*N_CROSS-1:0] sensor_fault
);

  localparam int NS     = 3 * N_CROSS;
  localparam int DB_W   = $clog2(DEBOUNCE_CYC + 1);
  localparam int HOLD_W = $clog2(CLEAR_HOLD + 1);
  localparam int FT_W   = $clog2(FAULT_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OCCUPIED = 2'd1,
    CLEARING = 2'd2
  } xing_state_e;

  // Sensor vectors use the same 3-bits-per-crossing layout as sensor_fault.
  logic [NS-1:0]      raw, sync_1, sync_2, deb;
  logic [DB_W-1:0]    db_cnt [NS];
  logic [1:0]         wx_1, wx_2;
  logic               storm;
  logic [2:0]         flt      [N_CROSS];
  logic [2:0]         odd_oh   [N_CROSS];
  logic [2:0]         odd_prev [N_CROSS];
  logic [FT_W-1:0]    ft_cnt   [N_CROSS];
  logic [N_CROSS-1:0] v_hi;
  xing_state_e        state    [N_CROSS];
  xing_state_e        state_nx [N_CROSS];
  logic [HOLD_W-1:0]  hold     [N_CROSS];
  logic [HOLD_W-1:0]  hold_nx  [N_CROSS];
  logic [N_CROSS-1:0] arrive_nx, depart_nx;
`ifdef FAULT_AUTOCLEAR_EN
  logic [FT_W-1:0]    rec_cnt  [N_CROSS];
`endif

  // One-hot of the sensor that disagrees with the other two; 000 when all agree.
  function automatic logic [2:0] odd_onehot(input logic [2:0] d);
    case (d)
      3'b001, 3'b110: return 3'b001;
      3'b010, 3'b101: return 3'b010;
      3'b100, 3'b011: return 3'b100;
      default:        return 3'b000;
    endcase
  endfunction

  // Faulted sensors are masked out. Any fault or a storm drops the threshold
  // to one vote, so a crossing fails towards "occupied".
  function automatic logic vote_high(input logic [2:0] d, input logic [2:0] f,
                                     input logic stormy);
    logic [2:0] live;
    logic [1:0] votes;
    logic [1:0] thr;
    live  = d & ~f;
    votes = {1'b0, live[0]} + {1'b0, live[1]} + {1'b0, live[2]};
    thr   = (stormy || (|f)) ? 2'd1 : 2'd2;
    return votes >= thr;
  endfunction

  assign storm = (wx_2 == 2'b10) || (wx_2 == 2'b11);

  always_comb begin
    raw          = '0;
    sensor_fault = '0;
    v_hi         = '0;
    for (int i = 0; i < N_CROSS; i++) begin
      raw[3*i]     = ir_sensor[i];
      raw[3*i+1]   = vib_sensor[i];
      raw[3*i+2]   = rfid_valid[i];
      sensor_fault[3*i +: 3] = flt[i];
      odd_oh[i]    = odd_onehot(deb[3*i +: 3]);
      v_hi[i]      = vote_high(deb[3*i +: 3], flt[i], storm);
    end
  end

  // The debounced value only moves after DEBOUNCE_CYC consecutive differing
  // samples. The counter restarts on any agreeing sample.
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      sync_1 <= '0;
      sync_2 <= '0;
      wx_1   <= '0;
      wx_2   <= '0;
      deb    <= '0;
      for (int s = 0; s < NS; s++) db_cnt[s] <= '0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
      wx_1   <= weather_mode;
      wx_2   <= wx_1;
      for (int s = 0; s < NS; s++) begin
        if (sync_2[s] == deb[s]) begin
          db_cnt[s] <= '0;
        end else if (db_cnt[s] == DB_W'(DEBOUNCE_CYC - 1)) begin
          deb[s]    <= sync_2[s];
          db_cnt[s] <= '0;
        end else begin
          db_cnt[s] <= db_cnt[s] + DB_W'(1);
        end
      end
    end
  end

  always_comb begin
    arrive_nx = '0;
    depart_nx = '0;
    for (int i = 0; i < N_CROSS; i++) begin
      state_nx[i] = state[i];
      hold_nx[i]  = hold[i];
      case (state[i])
        IDLE: begin
          if (v_hi[i]) begin
            state_nx[i]  = OCCUPIED;
            arrive_nx[i] = 1'b1;
          end
        end
        OCCUPIED: begin
          if (!v_hi[i]) begin
            state_nx[i] = CLEARING;
            hold_nx[i]  = '0;
          end
        end
        CLEARING: begin
          if (v_hi[i]) begin
            state_nx[i] = OCCUPIED;
          end else if (hold[i] == HOLD_W'(CLEAR_HOLD - 1)) begin
            state_nx[i]  = IDLE;
            depart_nx[i] = 1'b1;
            hold_nx[i]   = '0;
          end else begin
            hold_nx[i] = hold[i] + HOLD_W'(1);
          end
        end
        default: state_nx[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CROSS; i++) begin
        state[i] <= IDLE;
        hold[i]  <= '0;
      end
      train_present <= '0;
      train_arrive  <= '0;
      train_depart  <= '0;
    end else begin
      for (int i = 0; i < N_CROSS; i++) begin
        state[i]         <= state_nx[i];
        hold[i]          <= hold_nx[i];
        train_present[i] <= (state_nx[i] != IDLE);
      end
      train_arrive <= arrive_nx;
      train_depart <= depart_nx;
    end
  end

  // odd_prev remembers which sensor the running timer belongs to, so a change
  // of odd sensor restarts the count at 1 for the new sensor. Odd sensors that
  // are already flagged are treated as "no disagreement".
  always_ff @(posedge clk_50mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CROSS; i++) begin
        flt[i]      <= '0;
        odd_prev[i] <= '0;
        ft_cnt[i]   <= '0;
`ifdef FAULT_AUTOCLEAR_EN
        rec_cnt[i]  <= '0;
`endif
      end
    end else begin
      for (int i = 0; i < N_CROSS; i++) begin
        if (|(odd_oh[i] & ~flt[i])) begin
          if (odd_oh[i] == odd_prev[i]) begin
            if (ft_cnt[i] == FT_W'(FAULT_TIMEOUT - 1)) begin
              flt[i]      <= flt[i] | odd_oh[i];
              ft_cnt[i]   <= '0;
              odd_prev[i] <= '0;
            end else begin
              ft_cnt[i] <= ft_cnt[i] + FT_W'(1);
            end
          end else begin
            odd_prev[i] <= odd_oh[i];
            ft_cnt[i]   <= FT_W'(1);
          end
        end else begin
          odd_prev[i] <= '0;
          ft_cnt[i]   <= '0;
        end
`ifdef FAULT_AUTOCLEAR_EN
        // All three agreeing means every faulted sensor is back in line.
        if ((|flt[i]) && (odd_oh[i] == 3'b000)) begin
          if (rec_cnt[i] == FT_W'(FAULT_TIMEOUT - 1)) begin
            flt[i]     <= '0;
            rec_cnt[i] <= '0;
          end else begin
            rec_cnt[i] <= rec_cnt[i] + FT_W'(1);
          end
        end else begin
          rec_cnt[i] <= '0;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_sensor_fusion_voter.sv
// tb_sensor_fusion_voter
//   Directed scenarios plus a random phase for sensor_fusion_voter. Every cycle
//   all outputs are compared against a behavioural model. The model tracks
//   timestamps (last agreement, start of low vote, start of a disagreement)
//   rather than counters. Key latencies are also checked against fixed numbers.
module tb_sensor_fusion_voter;

  localparam int N_CROSS       = 4;
  localparam int DEBOUNCE_CYC  = 16;
  localparam int CLEAR_HOLD    = 64;
  localparam int FAULT_TIMEOUT = 1024;

  logic        clk_50mhz = 1'b0;
  logic        rst_n;
  logic [3:0]  ir_sensor, vib_sensor, rfid_valid;
  logic [1:0]  weather_mode;
  logic [3:0]  train_present, train_arrive, train_depart;
  logic [11:0] sensor_fault;

  always #10 clk_50mhz = ~clk_50mhz;

  sensor_fusion_voter #(
    .N_CROSS      (N_CROSS),
    .DEBOUNCE_CYC (DEBOUNCE_CYC),
    .CLEAR_HOLD   (CLEAR_HOLD),
    .FAULT_TIMEOUT(FAULT_TIMEOUT)
  ) dut (
    .clk_50mhz    (clk_50mhz),
    .rst_n        (rst_n),
    .ir_sensor    (ir_sensor),
    .vib_sensor   (vib_sensor),
    .rfid_valid   (rfid_valid),
    .weather_mode (weather_mode),
    .train_present(train_present),
    .train_arrive (train_arrive),
    .train_depart (train_depart),
    .sensor_fault (sensor_fault)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  logic [11:0] m_s1, m_s2, m_deb, m_fault;
  int          m_agree_at [12];
  logic [1:0]  m_w1, m_w2;
  logic [3:0]  m_present, m_arrive, m_depart;
  int          m_low_since [4];
  int          m_odd_who [4];
  int          m_odd_since [4];

  // observations of the DUT within the current scenario
  int          arrive_cnt [4];
  int          depart_cnt [4];
  int          fall_cnt [4];
  int          first_arrive [4];
  int          first_depart [4];
  int          first_fault [12];
  logic [3:0]  prev_present;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic modelReset();
    m_s1 = '0; m_s2 = '0; m_deb = '0; m_fault = '0;
    m_w1 = '0; m_w2 = '0;
    m_present = '0; m_arrive = '0; m_depart = '0;
    for (int s = 0; s < 12; s++) m_agree_at[s] = cyc;
    for (int i = 0; i < 4; i++) begin
      m_low_since[i] = -1;
      m_odd_who[i]   = -1;
      m_odd_since[i] = 0;
    end
  endtask

  // One clock edge of the model; everything reads pre-edge values.
  task automatic modelStep(input logic [11:0] raw, input logic [1:0] wx);
    int live, thr, ones, odd;
    logic anyf;
    logic [3:0] vhi;
    for (int i = 0; i < 4; i++) begin
      live = 0;
      anyf = 1'b0;
      for (int k = 0; k < 3; k++) begin
        if (m_deb[3*i+k] && !m_fault[3*i+k]) live++;
        if (m_fault[3*i+k]) anyf = 1'b1;
      end
      thr = (m_w2 >= 2'd2 || anyf) ? 1 : 2;
      vhi[i] = (live >= thr);
    end
    m_arrive = '0;
    m_depart = '0;
    for (int i = 0; i < 4; i++) begin
      if (!m_present[i]) begin
        if (vhi[i]) begin
          m_present[i] = 1'b1;
          m_arrive[i]  = 1'b1;
          m_low_since[i] = -1;
        end
      end else if (vhi[i]) begin
        m_low_since[i] = -1;
      end else if (m_low_since[i] < 0) begin
        m_low_since[i] = cyc;
      end else if (cyc - m_low_since[i] == CLEAR_HOLD) begin
        m_present[i]   = 1'b0;
        m_depart[i]    = 1'b1;
        m_low_since[i] = -1;
      end
    end
    for (int i = 0; i < 4; i++) begin
      ones = int'(m_deb[3*i]) + int'(m_deb[3*i+1]) + int'(m_deb[3*i+2]);
      odd  = -1;
      for (int k = 0; k < 3; k++)
        if ((ones == 1 && m_deb[3*i+k]) || (ones == 2 && !m_deb[3*i+k])) odd = k;
      if (odd >= 0 && !m_fault[3*i+odd]) begin
        if (m_odd_who[i] == odd) begin
          if (cyc - m_odd_since[i] == FAULT_TIMEOUT - 1) begin
            m_fault[3*i+odd] = 1'b1;
            m_odd_who[i]     = -1;
          end
        end else begin
          m_odd_who[i]   = odd;
          m_odd_since[i] = cyc;
        end
      end else begin
        m_odd_who[i] = -1;
      end
    end
    for (int s = 0; s < 12; s++) begin
      if (m_s2[s] == m_deb[s]) begin
        m_agree_at[s] = cyc;
      end else if (cyc - m_agree_at[s] == DEBOUNCE_CYC) begin
        m_deb[s]      = m_s2[s];
        m_agree_at[s] = cyc;
      end
    end
    m_s2 = m_s1;
    m_s1 = raw;
    m_w2 = m_w1;
    m_w1 = wx;
  endtask

  task automatic clearObs();
    for (int i = 0; i < 4; i++) begin
      arrive_cnt[i] = 0; depart_cnt[i] = 0; fall_cnt[i] = 0;
      first_arrive[i] = -1; first_depart[i] = -1;
    end
    for (int s = 0; s < 12; s++) first_fault[s] = -1;
    prev_present = train_present;
  endtask

  // Drive one cycle of inputs (called at a falling edge), advance the model,
  // then compare at the next falling edge.
  task automatic applyStimulus(input logic [3:0] ir_v, input logic [3:0] vib_v,
                               input logic [3:0] rfid_v, input logic [1:0] wx_v);
    logic [11:0] raw;
    ir_sensor    = ir_v;
    vib_sensor   = vib_v;
    rfid_valid   = rfid_v;
    weather_mode = wx_v;
    for (int i = 0; i < 4; i++) begin
      raw[3*i] = ir_v[i]; raw[3*i+1] = vib_v[i]; raw[3*i+2] = rfid_v[i];
    end
    cyc++;
    if (!rst_n) modelReset();
    else modelStep(raw, wx_v);
    @(posedge clk_50mhz);
    @(negedge clk_50mhz);
    checkOutput("present", {28'd0, train_present}, {28'd0, m_present});
    checkOutput("arrive",  {28'd0, train_arrive},  {28'd0, m_arrive});
    checkOutput("depart",  {28'd0, train_depart},  {28'd0, m_depart});
    checkOutput("fault",   {20'd0, sensor_fault},  {20'd0, m_fault});
    for (int i = 0; i < 4; i++) begin
      if (train_arrive[i]) begin
        arrive_cnt[i]++;
        if (first_arrive[i] < 0) first_arrive[i] = cyc;
      end
      if (train_depart[i]) begin
        depart_cnt[i]++;
        if (first_depart[i] < 0) first_depart[i] = cyc;
      end
      if (prev_present[i] && !train_present[i]) fall_cnt[i]++;
    end
    for (int s = 0; s < 12; s++)
      if (sensor_fault[s] && first_fault[s] < 0) first_fault[s] = cyc;
    prev_present = train_present;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    modelReset();
    applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    rst_n = 1'b1;
  endtask

  initial begin
    int s0;
    int sf;
    logic [3:0] r_ir, r_vib, r_rfid, hi;
    logic [1:0] r_wx;

    rst_n = 1'b0;
    ir_sensor = '0; vib_sensor = '0; rfid_valid = '0; weather_mode = '0;
    modelReset();
    clearObs();
    for (int k = 0; k < 3; k++) applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("reset_present", {28'd0, train_present}, 32'd0);
    checkOutput("reset_fault",   {20'd0, sensor_fault},  32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);

    $display("[TB] scenario 1: full train on crossing 0");
    clearObs();
    s0 = cyc + 1;
    for (int k = 0; k < 500; k++) applyStimulus(4'h1, 4'h1, 4'h1, 2'b00);
    sf = cyc + 1;
    for (int k = 0; k < 120; k++) applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("t1_arrive_lat", first_arrive[0] - s0 + 1, 19);
    checkOutput("t1_depart_lat", first_depart[0] - sf + 1, 83);
    checkOutput("t1_arrive_cnt", arrive_cnt[0], 1);
    checkOutput("t1_fall_cnt",   fall_cnt[0], 1);
    checkOutput("t1_faults",     {20'd0, sensor_fault}, 32'd0);

    $display("[TB] scenario 2: crossing 2 with IR stuck low");
    clearObs();
    s0 = cyc + 1;
    for (int k = 0; k < 1200; k++) applyStimulus(4'h0, 4'h4, 4'h4, 2'b00);
    checkOutput("t2_arrive_lat", first_arrive[2] - s0 + 1, 19);
    checkOutput("t2_fault_lat",  first_fault[6] - s0 + 1, 2 + DEBOUNCE_CYC + FAULT_TIMEOUT);
    checkOutput("t2_other_faults", {20'd0, sensor_fault & ~12'h040}, 32'd0);
    for (int k = 0; k < 120; k++) applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("t2_fault_sticky", {31'd0, sensor_fault[6]}, 32'd1);
    doReset();
    checkOutput("t2_fault_cleared", {20'd0, sensor_fault}, 32'd0);

    $display("[TB] scenario 3: single vibration sensor, clear then storm");
    clearObs();
    for (int k = 0; k < 200; k++) applyStimulus(4'h0, 4'h2, 4'h0, 2'b00);
    for (int k = 0; k < 80; k++)  applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("t3_clear_no_arrive", arrive_cnt[1], 0);
    for (int k = 0; k < 5; k++)   applyStimulus(4'h0, 4'h0, 4'h0, 2'b10);
    clearObs();
    s0 = cyc + 1;
    for (int k = 0; k < 200; k++) applyStimulus(4'h0, 4'h2, 4'h0, 2'b10);
    sf = cyc + 1;
    for (int k = 0; k < 120; k++) applyStimulus(4'h0, 4'h0, 4'h0, 2'b10);
    checkOutput("t3_storm_arrive_lat", first_arrive[1] - s0 + 1, 19);
    checkOutput("t3_storm_depart_lat", first_depart[1] - sf + 1, 83);
    for (int k = 0; k < 5; k++)   applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);

    $display("[TB] scenario 4: short glitch on crossing 3");
    clearObs();
    for (int k = 0; k < 10; k++) applyStimulus(4'h8, 4'h8, 4'h8, 2'b00);
    for (int k = 0; k < 60; k++) applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("t4_no_arrive", arrive_cnt[3], 0);
    checkOutput("t4_no_present", {31'd0, train_present[3]}, 32'd0);

    $display("[TB] scenario 5: brief dropout on an occupied crossing");
    clearObs();
    for (int k = 0; k < 100; k++) applyStimulus(4'h1, 4'h1, 4'h1, 2'b00);
    for (int k = 0; k < 30; k++)  applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    for (int k = 0; k < 100; k++) applyStimulus(4'h1, 4'h1, 4'h1, 2'b00);
    checkOutput("t5_single_arrive", arrive_cnt[0], 1);
    checkOutput("t5_no_fall", fall_cnt[0], 0);
    checkOutput("t5_no_depart", depart_cnt[0], 0);
    for (int k = 0; k < 120; k++) applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);
    checkOutput("t5_final_depart", depart_cnt[0], 1);

    $display("[TB] scenario 6: overlapping trains and mid-run reset");
    clearObs();
    s0 = cyc + 1;
    for (int t = 0; t < 2300; t++) begin
      for (int i = 0; i < 4; i++) hi[i] = (i < 3) && (t >= 1000*i) && (t < 1000*i + 1500);
      applyStimulus(hi, hi, hi, 2'b00);
    end
    for (int i = 0; i < 3; i++)
      checkOutput($sformatf("t6_arrive_lat%0d", i), first_arrive[i] - (s0 + 1000*i) + 1, 19);
    checkOutput("t6_depart_lat0", first_depart[0] - (s0 + 1500) + 1, 83);
    checkOutput("t6_present_before_rst", {28'd0, train_present}, 32'h6);
    #5;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("t6_rst_present", {28'd0, train_present}, 32'd0);
    checkOutput("t6_rst_arrive",  {28'd0, train_arrive},  32'd0);
    checkOutput("t6_rst_depart",  {28'd0, train_depart},  32'd0);
    for (int k = 0; k < 3; k++) applyStimulus(4'h6, 4'h6, 4'h6, 2'b00);
    rst_n = 1'b1;
    clearObs();
    for (int t = 0; t < 200; t++) applyStimulus(4'h6, 4'h6, 4'h6, 2'b00);
    checkOutput("t6_no_depart_after_rst", depart_cnt[1] + depart_cnt[2], 0);
    for (int t = 0; t < 120; t++) applyStimulus(4'h0, 4'h0, 4'h0, 2'b00);

    $display("[TB] scenario 7: random sensor activity");
    r_ir = '0; r_vib = '0; r_rfid = '0; r_wx = '0;
    for (int t = 0; t < 3000; t++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 24) == 0) r_ir[i]   = ~r_ir[i];
        if ($urandom_range(0, 24) == 0) r_vib[i]  = ~r_vib[i];
        if ($urandom_range(0, 24) == 0) r_rfid[i] = ~r_rfid[i];
      end
      if ($urandom_range(0, 399) == 0) r_wx = 2'($urandom_range(0, 3));
      applyStimulus(r_ir, r_vib, r_rfid, r_wx);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sensor_fusion_voter.md
Name: sensor_fusion_voter

Overview:
Upstream conditioning stage for the railway crossing controller. It takes the raw IR, vibration and RFID signals for each crossing, then synchronises, debounces and majority-votes them. It produces one clean train-presence signal per crossing, plus arrival/departure pulses and sticky per-sensor fault flags. Its outputs feed the per-crossing barrier/light state machines and the efficiency scoring logic.

Parameters:
N_CROSS, 4, number of crossings.
DEBOUNCE_CYC, 16, consecutive stable synchronised samples needed before a debounced sensor changes (must be ≥2).
CLEAR_HOLD, 64, cycles the vote must stay below threshold before a departure is declared.
FAULT_TIMEOUT, 1024, consecutive cycles of odd-one-out disagreement before a sensor is flagged faulty.

Ports:
clk_50mhz, input, 1, system clock; all logic on the rising edge.
rst_n, input, 1, asynchronous active-low reset.
ir_sensor, input, N_CROSS, raw IR detector; bit i = crossing i.
vib_sensor, input, N_CROSS, raw vibration detector.
rfid_valid, input, N_CROSS, raw RFID tag-valid signal.
weather_mode, input, 2, 00 clear, 01 fog, 10 storm, 11 treated as storm; synchronised internally.
train_present, output, N_CROSS, crossing occupied (OCCUPIED or CLEARING).
train_arrive, output, N_CROSS, 1-cycle pulse on IDLE->OCCUPIED.
train_depart, output, N_CROSS, 1-cycle pulse on CLEARING->IDLE.
sensor_fault, output, 3*N_CROSS, sticky fault flags; bits [3i+0]=IR, [3i+1]=VIB, [3i+2]=RFID of crossing i.

Behaviour:
- Reset (async, rst_n=0): all outputs 0, all FSMs IDLE, debounced values 0, all counters 0, faults cleared. Assertion mid-operation drops train_present immediately, with no depart pulse.
- Synchroniser: 2 flops per raw input and per weather_mode bit.
- Debounce: a saturating counter per sensor.
  - Counts while the synchronised value differs from the debounced value.
  - Resets to 0 on any sample equal to the debounced value.
  - The debounced value flips when the count reaches DEBOUNCE_CYC.
- Masking: a sensor with its fault bit set contributes 0 to the vote.
- Vote: votes = number of unmasked debounced sensors high (0..3).
  - Threshold is 2 normally.
  - Threshold is 1 if weather is storm or any fault bit at that crossing is set (fail-safe).
  - v_hi = votes ≥ threshold.
- Per-crossing FSM (registered outputs):
  - IDLE -> OCCUPIED when v_hi; train_arrive=1 for one cycle.
  - OCCUPIED -> CLEARING when !v_hi; the hold counter loads 0.
  - CLEARING -> OCCUPIED when v_hi, with no pulse.
  - CLEARING -> IDLE when the hold counter reaches CLEAR_HOLD-1 with !v_hi; train_depart=1 for one cycle.
- Latency from the first edge sampling a new raw level on all sensors:
  - train_arrive asserts at cycle 2+DEBOUNCE_CYC+1 (19 at defaults).
  - train_depart asserts at 2+DEBOUNCE_CYC+CLEAR_HOLD+1 (83).
- Fault timer, one per crossing:
  - Odd-one-out case: exactly one debounced sensor differs from the other two. The timer counts while the same sensor is the odd one.
  - It resets when the odd sensor's identity changes or the disagreement disappears.
  - On reaching FAULT_TIMEOUT, that sensor's sensor_fault bit is set.
  - Faults are sticky; the timer then holds at 0 for that crossing.
  - An odd sensor that is already faulted is ignored.
- Crossings are fully independent. Simultaneous events on different crossings are all processed in the same cycle.
- weather_mode changes take effect on threshold 2 cycles later and may move an FSM in either direction immediately.

Optional Feature:
FAULT_AUTOCLEAR_EN:
- Defined: a faulted sensor whose debounced value agrees with both others for FAULT_TIMEOUT consecutive cycles has its fault bit cleared, and it rejoins the vote. A separate recovery counter exists per crossing.
- Undefined: faults stay sticky until rst_n.

Test Plan:
1. Clear weather; crossing 0 all sensors high 500 cycles then low -> train_arrive[0] pulse at cycle 19; train_present[0]=1 throughout; train_depart[0] pulse 83 cycles after the fall; no faults.
2. Clear weather; crossing 2 with IR stuck 0, vib+rfid high 1200 cycles -> arrive at 19; sensor_fault[6] set 1024 cycles after the vib/rfid debounced rise; other fault bits remain 0.
3. Only vib_sensor[1] high 200 cycles: weather 00 -> no arrive; weather 10 -> arrive at 19 and depart 83 after the fall.
4. All sensors at crossing 3 pulse high for 10 cycles (< DEBOUNCE_CYC) -> no train_arrive, train_present stays 0.
5. Occupied crossing 0; sensors drop for 30 cycles then return -> no depart, no second arrive, train_present never falls.
6. Trains on crossings 0/1/2 overlapping (starts 0, 1000, 2000 cycles) -> independent pulses with correct timing; rst_n low mid-run -> all outputs 0 asynchronously.
